// File: rtl/izh_pkg.sv
// Shared types, constants and saturation helpers for the Izhikevich neuron array.
package izh_pkg;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_ADDR   = 2'd1,
        LD_DATA   = 2'd2,
        LD_COMMIT = 2'd3
    } ld_state_t;

    localparam int V_TH     = 30;
    localparam int V_INIT   = -65;
    localparam int K_SQ     = 41;   // 0.04 scaled by 2^10
    localparam int K_LIN    = 5;
    localparam int K_OFS    = 140;
    localparam int SQ_SHIFT = 10;

    // Clamp a wide signed value into the signed w-bit range.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Clamp a wide signed value into -128..127 for the membrane monitor.
    function automatic logic [7:0] clamp8(input logic signed [63:0] x);
        if (x > 64'sd127) begin
            return 8'h7f;
        end else if (x < -64'sd128) begin
            return 8'h80;
        end
        return x[7:0];
    endfunction

endpackage

// File: rtl/izh_neuron_array_if.sv
// Control, serial-load and status signals of the neuron array, bundled as one bus.
interface izh_neuron_array_if #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
) ();
    logic                  enable;
    logic                  input_enable;
    logic [NUM_CH*8-1:0]   stimulus_in;
    logic                  load_mode;
    logic                  serial_data;
    logic [CH_BITS-1:0]    mon_sel;
    logic [7:0]            membrane_out;
    logic [NUM_CH-1:0]     spike_out;
    logic                  params_ready;
    logic                  frame_done;
    logic                  addr_err;
    logic [2:0]            debug_state;

    modport master (
        output enable, input_enable, stimulus_in, load_mode, serial_data, mon_sel,
        input  membrane_out, spike_out, params_ready, frame_done, addr_err, debug_state
    );

    modport slave (
        input  enable, input_enable, stimulus_in, load_mode, serial_data, mon_sel,
        output membrane_out, spike_out, params_ready, frame_done, addr_err, debug_state
    );
endinterface

// File: rtl/izh_update_dp.sv
// One Izhikevich integration step for a single channel; shared by all channels.
module izh_update_dp import izh_pkg::*; #(
    parameter int W        = 12,
    parameter int AB_FRAC  = 8,
    parameter int DT_SHIFT = 1,
    parameter int V_TH     = izh_pkg::V_TH
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] u,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    input  logic        [7:0]   stim,
    output logic signed [W-1:0] v_next,
    output logic signed [W-1:0] u_next,
    output logic                spike
);
    // Wide enough that 41*v*v and a*(b*v - u) never wrap for any W-bit inputs.
    localparam int IW = 2 * W + 8;

    logic signed [IW-1:0] vx, ux, ax, bx, dx, ix;
    logic signed [IW-1:0] sq, dv, vn, bv, du, un, uj;

    // Evaluate dv/du, detect the spike and saturate back to W bits.
    always_comb begin
        vx = IW'(v);
        ux = IW'(u);
        ax = IW'(a);
        bx = IW'(b);
        dx = IW'(d);
        ix = IW'({1'b0, stim});

        sq = (IW'(K_SQ) * vx * vx) >>> SQ_SHIFT;
        dv = sq + IW'(K_LIN) * vx + IW'(K_OFS) - ux + ix;
        vn = vx + (dv >>> DT_SHIFT);

        bv = (bx * vx) >>> AB_FRAC;
        du = (ax * (bv - ux)) >>> AB_FRAC;
        un = ux + du;
        uj = un + dx;

        spike  = (vn >= IW'(V_TH));
        v_next = spike ? c : W'(sat_w(64'(vn), W));
        u_next = W'(sat_w(64'(spike ? uj : un), W));
    end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons with a framed serial parameter loader.
//
// Loader states:
//   state     | meaning
//   LD_IDLE   | waiting for load_mode; first frame bit is taken on entry
//   LD_ADDR   | shifting the channel address bits
//   LD_DATA   | shifting a, b, c, d (W bits each, MSB first)
//   LD_COMMIT | write params/ready of the addressed channel, or flag a bad address
module izh_neuron_array import izh_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int W        = 12,
    parameter int CH_BITS  = 2,
    parameter int AB_FRAC  = 8,
    parameter int DT_SHIFT = 1,
    parameter int V_TH     = izh_pkg::V_TH,
    parameter int V_INIT   = izh_pkg::V_INIT
) (
    input  logic           clk,
    input  logic           reset,
    izh_neuron_array_if.slave bus
);
    localparam int FW    = CH_BITS + 4 * W;
    localparam int CNT_W = $clog2(FW + 1);

    ld_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FW-1:0]        frame_q;

    logic signed [W-1:0]  v_q [NUM_CH];
    logic signed [W-1:0]  u_q [NUM_CH];
    logic signed [W-1:0]  a_q [NUM_CH];
    logic signed [W-1:0]  b_q [NUM_CH];
    logic signed [W-1:0]  c_q [NUM_CH];
    logic signed [W-1:0]  d_q [NUM_CH];
    logic [NUM_CH-1:0]    ready_q;
    logic [NUM_CH-1:0]    spike_q;
    logic [CH_BITS-1:0]   scan_q;

    logic [CH_BITS-1:0]   f_addr;
    logic signed [W-1:0]  f_a, f_b, f_c, f_d;
    logic                 addr_ok;

    logic signed [W-1:0]  dp_v, dp_u;
    logic                 dp_spike;
    logic [7:0]           dp_stim;
    logic [CH_BITS-1:0]   mon_idx;

    // Frame layout once fully shifted: addr | a | b | c | d, d in the LSBs.
    assign f_addr  = frame_q[FW-1 -: CH_BITS];
    assign f_a     = frame_q[4*W-1 -: W];
    assign f_b     = frame_q[3*W-1 -: W];
    assign f_c     = frame_q[2*W-1 -: W];
    assign f_d     = frame_q[W-1:0];
    assign addr_ok = ({1'b0, f_addr} < (CH_BITS + 1)'(NUM_CH));

    assign dp_stim = bus.stimulus_in[{scan_q, 3'b000} +: 8];

    // Out-of-range monitor selects fall back to channel 0 rather than reading past the array.
    assign mon_idx = ({1'b0, bus.mon_sel} < (CH_BITS + 1)'(NUM_CH)) ? bus.mon_sel : '0;

    assign bus.spike_out   = spike_q;
    assign bus.debug_state = {1'b0, state_q};

    izh_update_dp #(
        .W        (W),
        .AB_FRAC  (AB_FRAC),
        .DT_SHIFT (DT_SHIFT),
        .V_TH     (V_TH)
    ) u_dp (
        .v      (v_q[scan_q]),
        .u      (u_q[scan_q]),
        .a      (a_q[scan_q]),
        .b      (b_q[scan_q]),
        .c      (c_q[scan_q]),
        .d      (d_q[scan_q]),
        .stim   (dp_stim),
        .v_next (dp_v),
        .u_next (dp_u),
        .spike  (dp_spike)
    );

    // Serial loader FSM and parameter register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LD_IDLE;
            cnt_q          <= '0;
            frame_q        <= '0;
            ready_q        <= '0;
            bus.frame_done <= 1'b0;
            bus.addr_err   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            bus.frame_done <= 1'b0;
            bus.addr_err   <= 1'b0;
            if (bus.enable) begin
                case (state_q)
                    LD_IDLE: begin
                        if (bus.load_mode) begin
                            frame_q <= {frame_q[FW-2:0], bus.serial_data};
                            cnt_q   <= CNT_W'(1);
                            state_q <= (CH_BITS == 1) ? LD_DATA : LD_ADDR;
                        end
                    end
                    LD_ADDR: begin
                        if (!bus.load_mode) begin
                            cnt_q   <= '0;
                            state_q <= LD_IDLE;
                        end else begin
                            frame_q <= {frame_q[FW-2:0], bus.serial_data};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(CH_BITS - 1)) begin
                                state_q <= LD_DATA;
                            end
                        end
                    end
                    LD_DATA: begin
                        if (!bus.load_mode) begin
                            cnt_q   <= '0;
                            state_q <= LD_IDLE;
                        end else begin
                            frame_q <= {frame_q[FW-2:0], bus.serial_data};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(FW - 1)) begin
                                state_q <= LD_COMMIT;
                            end
                        end
                    end
                    LD_COMMIT: begin
                        if (addr_ok) begin
                            a_q[f_addr]     <= f_a;
                            b_q[f_addr]     <= f_b;
                            c_q[f_addr]     <= f_c;
                            d_q[f_addr]     <= f_d;
                            ready_q[f_addr] <= 1'b1;
                            bus.frame_done  <= 1'b1;
                        end else begin
                            bus.addr_err    <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= LD_IDLE;
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= LD_IDLE;
                    end
                endcase
            end
        end
    end

    // Round-robin neuron update: one channel per enabled cycle; unloaded channels hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q  <= '0;
            spike_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                v_q[k] <= W'(V_INIT);
                u_q[k] <= '0;
            end
        end else if (bus.enable && bus.input_enable) begin
            if (ready_q[scan_q]) begin
                v_q[scan_q]     <= dp_v;
                u_q[scan_q]     <= dp_u;
                spike_q[scan_q] <= dp_spike;
            end else begin
                spike_q[scan_q] <= 1'b0;
            end
            scan_q <= (scan_q == CH_BITS'(NUM_CH - 1)) ? '0 : scan_q + CH_BITS'(1);
        end
    end

    // Registered monitor and readiness outputs, updated every cycle regardless of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.membrane_out <= clamp8(64'(V_INIT));
            bus.params_ready <= 1'b0;
        end else begin
            bus.membrane_out <= clamp8(64'(v_q[mon_idx]));
            bus.params_ready <= &ready_q;
        end
    end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Self-checking bench: loader frame table, spiking run, freeze window, bad-address instance.
`timescale 1ns/1ps
module tb_izh_neuron_array;

    localparam int NCH = 4;
    localparam int CHB = 2;
    localparam int WW  = 12;
    localparam int FW  = CHB + 4 * WW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    izh_neuron_array_if #(.NUM_CH(4), .CH_BITS(2)) ifa ();
    izh_neuron_array_if #(.NUM_CH(3), .CH_BITS(2)) ifb ();

    izh_neuron_array #(.NUM_CH(4), .W(12), .CH_BITS(2), .AB_FRAC(8), .DT_SHIFT(1),
                       .V_TH(30), .V_INIT(-65)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    izh_neuron_array #(.NUM_CH(3), .W(12), .CH_BITS(2), .AB_FRAC(8), .DT_SHIFT(1),
                       .V_TH(30), .V_INIT(-65)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int errors = 0;
    int checks = 0;

    // Reference model of instance A
    int mv [NCH];
    int mu [NCH];
    int ma [NCH];
    int mb [NCH];
    int mc [NCH];
    int md [NCH];
    bit [NCH-1:0] mready;
    bit [NCH-1:0] mspk;
    int mscan;

    typedef struct {
        logic [7:0]     mem;
        logic [NCH-1:0] spk;
        logic           pr;
        logic           fd;
        logic           ae;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int addr;
        int a;
        int b;
        int c;
        int d;
        int abort_bits;   // -1: full frame, else DATA bits sent before load_mode drops
        bit pre_check;    // monitor must still read -65 just before this commit
        bit exp_pr;       // params_ready expected after this frame
    } frame_vec_t;
    frame_vec_t ftab [5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat12(input longint x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return int'(x);
    endfunction

    function automatic logic [7:0] cl8(input int x);
        if (x > 127) return 8'h7f;
        if (x < -128) return 8'h80;
        return 8'(x);
    endfunction

    function automatic void model_update(input int k, input int stim);
        longint v  = mv[k];
        longint u  = mu[k];
        longint dv;
        longint vn;
        longint du;
        longint un;
        dv = ((41 * v * v) >>> 10) + 5 * v + 140 - u + stim;
        vn = v + (dv >>> 1);
        du = (ma[k] * (((mb[k] * v) >>> 8) - u)) >>> 8;
        un = u + du;
        if (vn >= 30) begin
            mv[k]   = mc[k];
            mu[k]   = sat12(un + md[k]);
            mspk[k] = 1'b1;
        end else begin
            mv[k]   = sat12(vn);
            mu[k]   = sat12(un);
            mspk[k] = 1'b0;
        end
    endfunction

    // One clock of instance A: predict, push, clock, pop and compare.
    task automatic step(input logic lm, input logic sd, input bit commit, input int caddr,
                        input int pa, input int pb, input int pc, input int pd);
        exp_t e;
        exp_t g;
        int k;
        ifa.load_mode   = lm;
        ifa.serial_data = sd;
        e.mem = cl8(mv[ifa.mon_sel]);
        e.pr  = &mready;
        e.fd  = commit && (caddr < NCH);
        e.ae  = commit && (caddr >= NCH);
        if (ifa.enable && ifa.input_enable) begin
            k = mscan;
            if (mready[k]) model_update(k, int'(ifa.stimulus_in[k*8 +: 8]));
            else mspk[k] = 1'b0;
            mscan = (mscan + 1) % NCH;
        end
        if (commit && caddr < NCH) begin
            ma[caddr] = pa;
            mb[caddr] = pb;
            mc[caddr] = pc;
            md[caddr] = pd;
            mready[caddr] = 1'b1;
        end
        e.spk = mspk;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        g = sbq.pop_front();
        chk("membrane_out", ifa.membrane_out, g.mem);
        chk("spike_out", ifa.spike_out, g.spk);
        chk("params_ready", ifa.params_ready, g.pr);
        chk("frame_done", ifa.frame_done, g.fd);
        chk("addr_err", ifa.addr_err, g.ae);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_a(input int addr, input int pa, input int pb, input int pc, input int pd,
                          input int abort_bits, input bit pre_check);
        logic [FW-1:0] bits;
        int n;
        bits = {2'(addr), 12'(pa), 12'(pb), 12'(pc), 12'(pd)};
        n = (abort_bits < 0) ? FW : CHB + abort_bits;
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[FW-1-i], 1'b0, 0, 0, 0, 0, 0);
            if (i == 0) chk("state_after_first_bit", ifa.debug_state, 1);
        end
        if (abort_bits >= 0) begin
            chk("state_before_abort", ifa.debug_state, 2);
            step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
            chk("state_after_abort", ifa.debug_state, 0);
        end else begin
            chk("state_commit", ifa.debug_state, 3);
            if (pre_check) chk("v_before_commit", ifa.membrane_out, 8'hBF);
            step(1'b0, 1'b0, 1'b1, addr, pa, pb, pc, pd);
            chk("state_after_commit", ifa.debug_state, 0);
        end
    endtask

    task automatic b_frame(input int addr, input int pa, input int pb, input int pc, input int pd,
                           output int nfd, output int nae);
        logic [FW-1:0] bits;
        bits = {2'(addr), 12'(pa), 12'(pb), 12'(pc), 12'(pd)};
        nfd = 0;
        nae = 0;
        for (int i = 0; i < FW + 3; i++) begin
            ifb.load_mode   = (i < FW);
            ifb.serial_data = (i < FW) ? bits[FW-1-i] : 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (ifb.frame_done) nfd++;
            if (ifb.addr_err) nae++;
        end
    endtask

    initial begin
        int nfd;
        int nae;
        int run1;
        int spikes1;
        int spikes_other;
        bit post_chk;
        logic [NCH-1:0] spk_hold;

        ftab[0] = '{addr: 1, a: 5, b: 51, c: -65, d: 8, abort_bits: -1, pre_check: 1'b1, exp_pr: 1'b0};
        ftab[1] = '{addr: 0, a: 5, b: 51, c: -65, d: 2, abort_bits: -1, pre_check: 1'b0, exp_pr: 1'b0};
        ftab[2] = '{addr: 2, a: 100, b: 200, c: -50, d: 30, abort_bits: 20, pre_check: 1'b0, exp_pr: 1'b0};
        ftab[3] = '{addr: 2, a: 5, b: 51, c: -65, d: 8, abort_bits: -1, pre_check: 1'b0, exp_pr: 1'b0};
        ftab[4] = '{addr: 3, a: 5, b: 51, c: -65, d: 8, abort_bits: -1, pre_check: 1'b0, exp_pr: 1'b1};

        for (int k = 0; k < NCH; k++) begin
            mv[k] = -65; mu[k] = 0; ma[k] = 0; mb[k] = 0; mc[k] = 0; md[k] = 0;
        end
        mready = '0;
        mspk   = '0;
        mscan  = 0;

        reset = 1'b1;
        ifa.enable = 1'b0; ifa.input_enable = 1'b0; ifa.stimulus_in = '0;
        ifa.load_mode = 1'b0; ifa.serial_data = 1'b0; ifa.mon_sel = 2'd1;
        ifb.enable = 1'b0; ifb.input_enable = 1'b0; ifb.stimulus_in = '0;
        ifb.load_mode = 1'b0; ifb.serial_data = 1'b0; ifb.mon_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_membrane", ifa.membrane_out, 8'hBF);
        chk("rst_spike", ifa.spike_out, 0);
        chk("rst_params_ready", ifa.params_ready, 0);
        chk("rst_debug_state", ifa.debug_state, 0);
        chk("rst_frame_done", ifa.frame_done, 0);
        chk("rst_addr_err", ifa.addr_err, 0);

        // Three-channel instance: bad address first, then the three legal channels.
        ifb.enable = 1'b1;
        b_frame(3, 5, 51, -65, 8, nfd, nae);
        chk("b_addr3_err_pulses", nae, 1);
        chk("b_addr3_done_pulses", nfd, 0);
        chk("b_addr3_params_ready", ifb.params_ready, 0);
        b_frame(0, 5, 51, -65, 8, nfd, nae);
        chk("b_ch0_done_pulses", nfd, 1);
        b_frame(1, 5, 51, -65, 8, nfd, nae);
        chk("b_ch1_err_pulses", nae, 0);
        chk("b_ch1_params_ready", ifb.params_ready, 0);
        b_frame(2, 5, 51, -65, 8, nfd, nae);
        chk("b_ch2_done_pulses", nfd, 1);
        chk("b_all_params_ready", ifb.params_ready, 1);
        chk("b_membrane_idle", ifb.membrane_out, 8'hBF);
        ifb.enable = 1'b0;

        // Instance A: frame table with the core running on zero stimulus.
        ifa.enable = 1'b1;
        ifa.input_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_a(ftab[i].addr, ftab[i].a, ftab[i].b, ftab[i].c, ftab[i].d,
                   ftab[i].abort_bits, ftab[i].pre_check);
            idle_steps(1);
            chk($sformatf("tab%0d_params_ready", i), ifa.params_ready, ftab[i].exp_pr);
        end

        // Channel 1 driven with 10; others at rest.
        ifa.stimulus_in = 32'h0000_0A00;
        run1 = 0; spikes1 = 0; spikes_other = 0; post_chk = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
            if (post_chk) begin
                chk("v_after_spike", ifa.membrane_out, 8'hBF);
                post_chk = 1'b0;
            end
            if (ifa.spike_out[1]) begin
                if (run1 == 0) begin
                    spikes1++;
                    post_chk = 1'b1;
                end
                run1++;
            end else if (run1 != 0) begin
                chk("spike_pulse_width", run1, NCH);
                run1 = 0;
            end
            if (ifa.spike_out[0] || ifa.spike_out[2] || ifa.spike_out[3]) spikes_other++;
        end
        chk("ch1_spiked_repeatedly", spikes1 >= 2, 1);
        chk("other_channels_silent", spikes_other, 0);

        // Core frozen while a new ch0 frame commits.
        ifa.input_enable = 1'b0;
        idle_steps(1);
        spk_hold = ifa.spike_out;
        send_a(0, 6, 40, -60, 4, -1, 1'b0);
        chk("frozen_spike_out", ifa.spike_out, spk_hold);
        ifa.input_enable = 1'b1;
        idle_steps(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/izh_neuron_array.md
Name: izh_neuron_array

Overview:
- Time-multiplexed, parametrised array of NUM_CH Izhikevich neurons sharing one arithmetic datapath.
- Each channel has its own parameters, loaded over a framed serial protocol, and its own stimulus byte.
- Channels are updated round-robin, one per enabled cycle.
- Drop-in successor to the single-neuron system at the top of the neuromorphic tile: per-channel spikes plus a selectable membrane monitor.

Parameters:
- NUM_CH, 4, number of neuron channels (2..16)
- W, 12, signed width of v, u, a, b, c, d
- CH_BITS, 2, address width = max(1, clog2(NUM_CH))
- AB_FRAC, 8, fractional bits of a and b (Q.8: a=0.02→5, b=0.2→51)
- DT_SHIFT, 1, right-shift applied to dv (dt = 2^-DT_SHIFT)
- V_TH, 30, spike threshold (mV)
- V_INIT, -65, reset value of v

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global enable; loader and core both freeze when low
- input_enable  in  1  gates neuron updates (core only)
- stimulus_in  in  NUM_CH*8  unsigned stimulus; byte k drives channel k
- load_mode  in  1  high while a serial frame is shifted in
- serial_data  in  1  serial bit, MSB first
- mon_sel  in  CH_BITS  channel shown on membrane_out
- membrane_out  out  8  registered v of channel mon_sel, clamped to -128..127
- spike_out  out  NUM_CH  per-channel spike flag
- params_ready  out  1  all channels loaded
- frame_done  out  1  one-cycle pulse on valid commit
- addr_err  out  1  one-cycle pulse when a frame address is >= NUM_CH
- debug_state  out  3  loader FSM state encoding

Behaviour:
Reset:
- All v = V_INIT, all u = 0, all params = 0, ready bits = 0.
- Scan counter = 0, membrane_out = clamp(V_INIT) = -65 (0xBF).
- spike_out, params_ready, frame_done, addr_err = 0; loader FSM in IDLE.

Loader FSM (advances only when enable=1):
- IDLE(0): load_mode=1 → ADDR, capturing the current bit as the first address bit.
- ADDR(1): shift CH_BITS bits total, then → DATA.
- DATA(2): shift 4*W bits in order a, b, c, d, then → COMMIT.
- COMMIT(3): for one cycle, the addressed channel's params and ready bit are written and frame_done pulses. If addr >= NUM_CH, nothing is written and addr_err pulses instead. Then → IDLE.
- load_mode=0 in ADDR or DATA: abort → IDLE; bit counter cleared, nothing written, no pulse.
- A commit does not touch v or u.

Core (advances only when enable & input_enable):
- Channel k = scan counter is processed; the counter wraps NUM_CH-1 → 0.
- Channel with ready=0: state held, spike_out[k] <= 0.
- Channel with ready=1, using I = zero-extended byte k and 2W+8-bit signed intermediates:
  - dv = ((41*v*v) >>> 10) + 5*v + 140 - u + I
  - vn = v + (dv >>> DT_SHIFT)
  - du = (a*(((b*v) >>> AB_FRAC) - u)) >>> AB_FRAC
  - un = u + du
- If vn >= V_TH: v <= c, u <= sat(un + d), spike_out[k] <= 1. Otherwise v <= sat(vn), u <= sat(un), spike_out[k] <= 0.
- sat() clamps to the signed W-bit range.
- spike_out[k] changes only in channel k's slot, so it holds for one full scan period.
- Latency: results are visible at the clock edge ending channel k's slot.
- If a commit and an update hit the same channel in the same cycle, the update uses the old params and the new params take effect on the next visit.

Outputs:
- membrane_out is registered from v[mon_sel] each cycle, regardless of enable.
- params_ready = AND of all ready bits, registered.

Decomposition:
- Package izh_pkg:
  - loader state enum (IDLE, ADDR, DATA, COMMIT)
  - V_TH, V_INIT, the 41/140/5 coefficients
  - sat function, 8-bit clamp function
- Sub-module izh_update_dp: purely combinational (v, u, a, b, c, d, I) → (v_next, u_next, spike). Instantiated once, shared by all channels.
- Loader FSM, register file and scan counter live in izh_neuron_array.

Test Plan:
- Reset → membrane_out = 0xBF, spike_out = 0, params_ready = 0, debug_state = 0.
- Load ch1 with a=5, b=51, c=-65, d=8 → frame_done pulses once. params_ready goes 1 only after ch0, ch2 and ch3 are also loaded. ch1's v stays -65 until the frame commits.
- All channels loaded, stimulus byte1 = 10, others 0, enable = input_enable = 1 → spike_out[1] periodic, with v[1] = -65 on the monitor after each spike. spike_out[0, 2, 3] stay 0. Each spike pulse lasts NUM_CH cycles.
- load_mode dropped after 20 DATA bits → debug_state returns to 0, no frame_done, ch params unchanged.
- Frame with addr = 3, NUM_CH = 3 instance → addr_err pulses, no ready bit set.
- input_enable = 0 for 50 cycles → scan counter, v, u and spike_out frozen. Loader still commits a frame during the window.
